// File: rtl/player_hit_controller_pkg.sv
// Shared types and hitbox geometry for the player hit controller.
package player_hit_controller_pkg;

    // Hitbox geometry in pixels.
    localparam int unsigned PLAYER_SIZE_X = 16;
    localparam int unsigned ENEMY_SIZE    = 16;
    localparam int unsigned STOMP_MARGIN  = 4;

    // Health loaded on reset.
    localparam logic [1:0] MAX_HEALTH = 2'd3;

    // Screen coordinates are 10 bits; one extra bit keeps sums from wrapping.
    typedef logic [10:0] coord_t;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } player_state_t;

    typedef struct packed {
        logic overlap;
        logic stomp;
    } contact_t;

    // Box overlap between one player and the enemy, plus the stomp
    // qualifier: the player's feet may sit at most STOMP_MARGIN pixels
    // below the enemy's top edge.
    function automatic contact_t classify(
        input logic [9:0] px,
        input logic [9:0] py,
        input logic [9:0] psy,
        input logic [9:0] ex,
        input logic [9:0] ey
    );
        contact_t c;
        coord_t   px_w;
        coord_t   py_w;
        coord_t   ex_w;
        coord_t   ey_w;
        coord_t   bottom;
        px_w      = {1'b0, px};
        py_w      = {1'b0, py};
        ex_w      = {1'b0, ex};
        ey_w      = {1'b0, ey};
        bottom    = py_w + {1'b0, psy};
        c.overlap = (px_w < ex_w + coord_t'(ENEMY_SIZE)) &&
                    (px_w + coord_t'(PLAYER_SIZE_X) > ex_w) &&
                    (py_w < ey_w + coord_t'(ENEMY_SIZE)) &&
                    (bottom > ey_w);
        c.stomp   = c.overlap && (bottom <= ey_w + coord_t'(STOMP_MARGIN));
        return c;
    endfunction

endpackage

// File: rtl/player_hit_fsm.sv
// Per-player health / invulnerability state machine.
// INVULN_FRAMES must be at least 2.
module player_hit_fsm
    import player_hit_controller_pkg::*;
#(
    parameter int unsigned INVULN_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick_i,
    input  logic       overlap_i,
    input  logic       stomp_i,
    input  logic       global_stomp_i,
    output logic [1:0] health_o,
    output logic       invuln_o,
    output logic       dead_o
);

    localparam int unsigned CNT_W = (INVULN_FRAMES > 2) ? $clog2(INVULN_FRAMES) : 1;
    // The hit frame itself counts as the first invulnerable frame, so the
    // counter starts one short and the player is hittable again exactly
    // INVULN_FRAMES ticks after the hit.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_FRAMES - 1);

    player_state_t    state_q, state_d;
    logic [1:0]       health_q, health_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             side_hit;

    // A stomp by either player kills the enemy, which cancels any damage.
    assign side_hit = overlap_i && !stomp_i && !global_stomp_i;

    // Next-state logic, advanced only on frame ticks.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d  = state_q;
        health_d = health_q;
        cnt_d    = cnt_q;
        if (tick_i) begin
            unique case (state_q)
                ST_ALIVE: begin
                    if (side_hit) begin
                        if (health_q <= 2'd1) begin
                            health_d = '0;
                            state_d  = ST_DEAD;
                        end else begin
                            health_d = health_q - 2'd1;
                            cnt_d    = CNT_LOAD;
                            state_d  = ST_INVULN;
                        end
                    end
                end
                ST_INVULN: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_ALIVE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DEAD: begin
                    health_d = '0;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
    end

    // State, health and invulnerability counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_ALIVE;
            health_q <= MAX_HEALTH;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            health_q <= health_d;
            cnt_q    <= cnt_d;
        end
    end

    assign health_o = health_q;
    assign invuln_o = (state_q == ST_INVULN);
    assign dead_o   = (state_q == ST_DEAD);

endmodule

// File: rtl/player_hit_controller.sv
// Player/enemy contact detection, health ownership and stomp signalling.
module player_hit_controller
    import player_hit_controller_pkg::*;
#(
    parameter int unsigned INVULN_FRAMES = 60,
    parameter logic [2:0]  ENEMY_LEVEL   = 3'b001
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [2:0] level_num,
    input  logic [9:0] mario_x,
    input  logic [9:0] mario_y,
    input  logic [9:0] luigi_x,
    input  logic [9:0] luigi_y,
    input  logic [9:0] mario_Size_Y,
    input  logic [9:0] luigi_Size_Y,
    input  logic [9:0] enemy_x,
    input  logic [9:0] enemy_y,
    input  logic       enemy_health,
    output logic [1:0] mario_health,
    output logic [1:0] luigi_health,
    output logic       mario_invuln,
    output logic       luigi_invuln,
    output logic       enemy_stomp,
    output logic       game_over
);

    logic [1:0] frame_sync_q;
    logic       frame_prev_q;
    logic       tick;
    logic       eval;
    contact_t   mario_c;
    contact_t   luigi_c;
    logic       mario_dead;
    logic       luigi_dead;
    logic       mario_overlap;
    logic       luigi_overlap;
    logic       mario_stomp;
    logic       luigi_stomp;
    logic       global_stomp;
    logic       enemy_stomp_q;
    logic       game_over_q;

    // Bring frame_clk into the Clk domain and remember the previous level.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_sync_q <= '0;
            frame_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the flops shift together.
            frame_sync_q <= {frame_sync_q[0], frame_clk};
            frame_prev_q <= frame_sync_q[1];
        end
    end

    assign tick = frame_sync_q[1] && !frame_prev_q;
    assign eval = tick && (level_num == ENEMY_LEVEL) && enemy_health;

    assign mario_c = classify(mario_x, mario_y, mario_Size_Y, enemy_x, enemy_y);
    assign luigi_c = classify(luigi_x, luigi_y, luigi_Size_Y, enemy_x, enemy_y);

    // Dead players no longer take part in any contact test.
    assign mario_overlap = eval && mario_c.overlap && !mario_dead;
    assign luigi_overlap = eval && luigi_c.overlap && !luigi_dead;
    assign mario_stomp   = mario_overlap && mario_c.stomp;
    assign luigi_stomp   = luigi_overlap && luigi_c.stomp;
    assign global_stomp  = mario_stomp || luigi_stomp;

    player_hit_fsm #(
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_mario_fsm (
        .Clk            (Clk),
        .Reset          (Reset),
        .tick_i         (tick),
        .overlap_i      (mario_overlap),
        .stomp_i        (mario_stomp),
        .global_stomp_i (global_stomp),
        .health_o       (mario_health),
        .invuln_o       (mario_invuln),
        .dead_o         (mario_dead)
    );

    player_hit_fsm #(
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_luigi_fsm (
        .Clk            (Clk),
        .Reset          (Reset),
        .tick_i         (tick),
        .overlap_i      (luigi_overlap),
        .stomp_i        (luigi_stomp),
        .global_stomp_i (global_stomp),
        .health_o       (luigi_health),
        .invuln_o       (luigi_invuln),
        .dead_o         (luigi_dead)
    );

    // One-cycle stomp pulse (tick is single-cycle) and registered game over.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            enemy_stomp_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            enemy_stomp_q <= global_stomp;
            game_over_q   <= mario_dead && luigi_dead;
        end
    end

    assign enemy_stomp = enemy_stomp_q;
    assign game_over   = game_over_q;

endmodule

// File: doc/player_hit_controller.md
Name: player_hit_controller

Overview:
- Player-side counterpart to the enemy block. Enemy logic reads player position and health. This block reads enemy position and liveness back, detects player/enemy contact each frame, and owns mario_health and luigi_health.
- Classifies each contact as a stomp (kills the enemy, sends a stomp pulse) or a side hit (costs the player one health unit, then grants invulnerability frames).
- Sits between the enemy controller and both player motion blocks. Its health outputs drive the enemy's health inputs.

Parameters:
- PLAYER_SIZE_X, 16, player hitbox width in pixels.
- ENEMY_SIZE, 16, enemy hitbox width and height in pixels.
- STOMP_MARGIN, 4, max pixels the player's bottom edge may sit below enemy top for a hit to count as a stomp.
- MAX_HEALTH, 3, health value loaded at reset (2-bit).
- INVULN_FRAMES, 60, frame ticks of invulnerability after a side hit.
- ENEMY_LEVEL, 3'b001, the only level_num in which collisions are evaluated.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vertical-sync frame strobe, asynchronous to Clk.
- level_num  in  3  current level.
- mario_x, mario_y  in  10 each  Mario top-left position.
- luigi_x, luigi_y  in  10 each  Luigi top-left position.
- mario_Size_Y, luigi_Size_Y  in  10 each  current player heights.
- enemy_x, enemy_y  in  10 each  enemy top-left position.
- enemy_health  in  1  1 = enemy alive.
- mario_health, luigi_health  out  2 each  current health; 0 = dead.
- mario_invuln, luigi_invuln  out  1 each  high while invulnerable.
- enemy_stomp  out  1  one-Clk pulse requesting enemy death.
- game_over  out  1  high when both players are dead.

Behaviour:
- Reset (Reset=0, async):
  - Both healths = MAX_HEALTH; invuln flags = 0.
  - enemy_stomp = 0; game_over = 0.
  - Both FSMs in ALIVE; counters = 0; sync flops = 0.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer. Rising-edge detect yields `tick`, high for exactly one Clk cycle per frame.
  - All state updates happen only in the tick cycle. Results are registered and visible the following Clk cycle.
- Evaluation gating: collisions are evaluated only when tick=1, level_num==ENEMY_LEVEL and enemy_health==1.
- Overlap test (per player, 11-bit unsigned arithmetic, no wrap):
  - px < ex+ENEMY_SIZE
  - px+PLAYER_SIZE_X > ex
  - py < ey+ENEMY_SIZE
  - py+Size_Y > ey
- Stomp: overlap AND (py+Size_Y) <= ey+STOMP_MARGIN. Any other overlap is a side hit.
- Per-player FSM:
  - ALIVE, side hit: health-1; load counter=INVULN_FRAMES; go to INVULN. If the new health is 0, go to DEAD instead.
  - ALIVE, stomp: no health change.
  - INVULN: decrement the counter each tick and ignore side hits. Leave for ALIVE when the counter reaches 0 (exactly INVULN_FRAMES ticks). Stomps are still honoured.
  - DEAD: terminal until reset. The player is ignored for all overlap tests. health stays 0.
- Invulnerability: *_invuln = (state==INVULN).
- Stomp output:
  - If any non-dead player stomps in a tick, enemy_stomp pulses high for one Clk cycle, registered one cycle after the tick.
  - Simultaneous stomps by both players produce one pulse.
- Stomp priority: stomp beats side hit in the same tick. The enemy dies, so no player takes damage that frame.
- Health floor: health never underflows below 0.
- game_over = registered (mario DEAD AND luigi DEAD).
- Level change: no state is cleared. Health and invulnerability carry across levels. Invulnerability counters keep counting on ticks even when not in ENEMY_LEVEL.
- Reset mid-invulnerability returns both players to ALIVE at full health immediately.

Decomposition:
- Shared package holds:
  - player_state_t enum (ALIVE, INVULN, DEAD);
  - hitbox constants (PLAYER_SIZE_X, ENEMY_SIZE, STOMP_MARGIN);
  - MAX_HEALTH.
- One natural sub-module, player_hit_fsm, instantiated twice (Mario, Luigi). It owns the health register, invuln counter and state. It takes tick, overlap, stomp and global_stomp, and outputs health, invuln and dead.
- Top level holds the synchronizer, overlap/stomp comparators, stomp OR/pulse logic and game_over.

Test Plan:
- Reset release, no contact, 10 frame ticks -> healths stay 3, invuln=0, enemy_stomp never asserts.
- Mario (300,384), Size_Y 16, enemy (304,384), enemy_health=1, level 1, one tick -> mario_health 3->2, mario_invuln=1. Holding overlap for 59 more ticks causes no further damage. At tick 61 (counter expired) with overlap still held, health goes 2->1.
- Mario (600,370), Size_Y 16, enemy (600,384): bottom 386 <= 388 -> one-cycle enemy_stomp, health unchanged. Luigi side-hitting in the same tick takes no damage.
- Luigi side hits on 3 separated frames (61-tick spacing) -> luigi_health 3,2,1,0, FSM DEAD. Later overlaps are ignored. Mario killed likewise -> game_over=1.
- level_num=3'b010, or enemy_health=0, with full overlap -> no health change, no stomp.
- Assert Reset low mid-invulnerability (counter≈30) -> outputs return to reset values asynchronously, before the next Clk edge.
